// File: rtl/serialtopar_sync.sv
// serialtopar_sync -- serial-to-parallel converter with comma-based word
// alignment for the PHY receive path (bit-clock domain).
//
// Hunts for COMMA at any bit offset, locks framing after LOCK_CNT aligned
// commas, then emits aligned parallel words with a one-cycle valid strobe.
// Also tracks IDLE symbols.
//
// Optional feature: define SERIALTOPAR_LOSS_DETECT_EN to drop lock after
// LOSS_CNT off-boundary commas seen while LOCKED. The block then realigns
// on the offending comma. Without the macro, LOCKED is terminal until reset.
//
// Ports:
//   clk_32f    in   serial bit clock, all logic on posedge
//   reset      in   asynchronous active-high reset
//   serial_in  in   serial data, MSB of each word first
//   data_out   out  last aligned word (WORD_W bits)
//   valid_out  out  one-cycle pulse, new word on data_out while locked
//   idle_out   out  idle status (set by IDLE_SYM, cleared by COMMA)
//   locked     out  high in state LOCKED
//   comma_det  out  registered pulse on a comma match at any offset
module serialtopar_sync #(
    parameter int                WORD_W   = 8,
    parameter logic [WORD_W-1:0] COMMA    = 8'hBC,
    parameter logic [WORD_W-1:0] IDLE_SYM = 8'h7C,
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              idle_out,
    output logic              locked,
    output logic              comma_det
);

    localparam int BCW = $clog2(WORD_W);
    localparam int CCW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CCW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              idle_q, idle_d;
    logic              comma_det_q, comma_det_d;

`ifdef SERIALTOPAR_LOSS_DETECT_EN
    localparam int MCW = $clog2(LOSS_CNT + 1);
    logic [MCW-1:0]    miss_cnt_q, miss_cnt_d;
`endif

    logic [WORD_W-1:0] cand;
    logic              is_comma, is_idle, boundary;

    always_comb begin
        cand     = {sh_q[WORD_W-2:0], serial_in};
        is_comma = (cand == COMMA);
        is_idle  = (cand == IDLE_SYM);
        boundary = (bit_cnt_q == BCW'(WORD_W - 1));

        state_d     = state_q;
        sh_d        = cand;
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        idle_d      = idle_q;
        comma_det_d = is_comma;
`ifdef SERIALTOPAR_LOSS_DETECT_EN
        miss_cnt_d  = miss_cnt_q;
`endif

        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    state_d     = ALIGN;
                    bit_cnt_d   = '0;
                    comma_cnt_d = CCW'(1);
                end
            end
            ALIGN: begin
                if (boundary) begin
                    data_d = cand;
                    if (is_comma) begin
                        if (comma_cnt_q >= CCW'(LOCK_CNT - 1)) begin
                            // The locking word itself is delivered as valid.
                            state_d     = LOCKED;
                            comma_cnt_d = CCW'(LOCK_CNT);
                            valid_d     = 1'b1;
                            idle_d      = 1'b0;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 1'b1;
                        end
                    end
                end else if (is_comma) begin
                    // Comma at a new offset: restart framing on it.
                    bit_cnt_d   = '0;
                    comma_cnt_d = CCW'(1);
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                    // Comma checked first so it wins if COMMA == IDLE_SYM.
                    if (is_comma) begin
                        idle_d = 1'b0;
`ifdef SERIALTOPAR_LOSS_DETECT_EN
                        miss_cnt_d = '0;
`endif
                    end else if (is_idle) begin
                        idle_d = 1'b1;
                    end
                end
`ifdef SERIALTOPAR_LOSS_DETECT_EN
                else if (is_comma) begin
                    if (miss_cnt_q >= MCW'(LOSS_CNT - 1)) begin
                        // Realign on this comma.
                        state_d     = ALIGN;
                        bit_cnt_d   = '0;
                        comma_cnt_d = CCW'(1);
                        miss_cnt_d  = '0;
                        idle_d      = 1'b0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            idle_q      <= 1'b0;
            comma_det_q <= 1'b0;
`ifdef SERIALTOPAR_LOSS_DETECT_EN
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            idle_q      <= idle_d;
            comma_det_q <= comma_det_d;
`ifdef SERIALTOPAR_LOSS_DETECT_EN
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign idle_out  = idle_q;
    assign locked    = (state_q == LOCKED);
    assign comma_det = comma_det_q;

endmodule

// File: tb/tb_serialtopar_sync.sv
// Directed bench for serialtopar_sync with default parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serialtopar_sync;

    localparam int W = 8;

    logic         clk_32f = 1'b0;
    logic         reset = 1'b1;
    logic         serial_in = 1'b0;
    logic [W-1:0] data_out;
    logic         valid_out, idle_out, locked, comma_det;

    int errors = 0, checks = 0;
    int cyc = 0, ncomma = 0, nvalid = 0, last_v = 0, gap = 0;
    logic [W-1:0] bc = 8'hBC;

    always #5 clk_32f = ~clk_32f;

    serialtopar_sync dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .idle_out  (idle_out),
        .locked    (locked),
        .comma_det (comma_det)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk_32f);
        #1;
        cyc++;
        if (comma_det) ncomma++;
        if (valid_out) begin
            nvalid++;
            gap    = cyc - last_v;
            last_v = cyc;
        end
    endtask

    // Sends the top n bits of w, MSB first.
    task automatic send_word_n(input logic [W-1:0] w, input int n);
        for (int i = W - 1; i >= W - n; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_word_n(w, W);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_32f);
        #1;
        chk("rst_data",   32'(data_out),  32'h0);
        chk("rst_valid",  32'(valid_out), 32'h0);
        chk("rst_idle",   32'(idle_out),  32'h0);
        chk("rst_locked", 32'(locked),    32'h0);
        chk("rst_cdet",   32'(comma_det), 32'h0);
        reset = 1'b0;

        // Offset hunt: 3 stray bits, 5 commas, then 0x55
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ncomma = 0; nvalid = 0;
        send_word(8'hBC);
        chk("hunt_cdet1", 32'(comma_det), 32'h1);
        chk("hunt_lock1", 32'(locked),    32'h0);
        send_word(8'hBC);
        chk("hunt_data2",  32'(data_out),  32'hBC);
        chk("hunt_valid2", 32'(valid_out), 32'h0);
        send_word(8'hBC);
        chk("hunt_lock3", 32'(locked), 32'h0);
        send_word(8'hBC);
        chk("hunt_lock4",  32'(locked),    32'h1);
        chk("hunt_valid4", 32'(valid_out), 32'h1);
        chk("hunt_data4",  32'(data_out),  32'hBC);
        send_word(8'hBC);
        chk("hunt_valid5", 32'(valid_out), 32'h1);
        chk("hunt_gap5",   32'(gap),       32'd8);
        send_word(8'h55);
        chk("hunt_data55",  32'(data_out),  32'h55);
        chk("hunt_valid55", 32'(valid_out), 32'h1);
        chk("hunt_gap55",   32'(gap),       32'd8);
        chk("hunt_nvalid",  32'(nvalid),    32'd3);
        chk("hunt_ncomma",  32'(ncomma),    32'd5);

        // IDLE tracking
        send_word(8'h7C);
        chk("idle_set",   32'(idle_out), 32'h1);
        chk("idle_data",  32'(data_out), 32'h7C);
        send_word(8'h00);
        chk("idle_hold",  32'(idle_out), 32'h1);
        chk("idle_data0", 32'(data_out), 32'h00);
        send_word(8'hBC);
        chk("idle_clr",   32'(idle_out), 32'h0);

        // Reset mid-word while locked and idle: outputs clear without a clock
        send_word(8'h7C);
        chk("pre_rst_idle", 32'(idle_out), 32'h1);
        send_word_n(8'hBC, 4);
        reset = 1'b1;
        #2;
        chk("arst_data",   32'(data_out),  32'h0);
        chk("arst_valid",  32'(valid_out), 32'h0);
        chk("arst_idle",   32'(idle_out),  32'h0);
        chk("arst_locked", 32'(locked),    32'h0);
        chk("arst_cdet",   32'(comma_det), 32'h0);
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;

        // Lock exactly on the last bit of the 4th comma
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        chk("relock_3", 32'(locked), 32'h0);
        send_word_n(8'hBC, 7);
        chk("relock_pre", 32'(locked), 32'h0);
        send_bit(bc[0]);
        chk("relock_4",     32'(locked),    32'h1);
        chk("relock_valid", 32'(valid_out), 32'h1);

        // Misaligned comma during ALIGN
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        nvalid = 0;
        send_word(8'hBC); send_word(8'hBC);
        chk("mis_lock_a", 32'(locked), 32'h0);
        send_word_n(8'h00, 3);
        send_word(8'hBC);
        chk("mis_cdet",   32'(comma_det), 32'h1);
        chk("mis_lock_b", 32'(locked),    32'h0);
        send_word(8'hBC); send_word(8'hBC);
        chk("mis_lock_c", 32'(locked), 32'h0);
        chk("mis_nvalid", 32'(nvalid), 32'd0);
        send_word(8'hBC);
        chk("mis_lock_d",  32'(locked),    32'h1);
        chk("mis_valid_d", 32'(valid_out), 32'h1);

        // Three commas at offset +2 while locked; old framing sees 0x2F
        ncomma = 0; nvalid = 0;
        send_word_n(8'h00, 2);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        chk("loss_ncomma", 32'(ncomma),   32'd3);
        chk("loss_nvalid", 32'(nvalid),   32'd3);
        chk("loss_data",   32'(data_out), 32'h2F);
`ifdef SERIALTOPAR_LOSS_DETECT_EN
        chk("loss_locked", 32'(locked), 32'h0);
        send_word(8'hBC);
        chk("loss_rdata",  32'(data_out),  32'hBC);
        chk("loss_rvalid", 32'(valid_out), 32'h0);
        chk("loss_rlock1", 32'(locked),    32'h0);
        send_word(8'hBC); send_word(8'hBC);
        chk("loss_rlock3", 32'(locked),    32'h1);
        chk("loss_rvld3",  32'(valid_out), 32'h1);
`else
        chk("loss_locked", 32'(locked), 32'h1);
        send_word(8'hBC);
        chk("loss_odata",  32'(data_out),  32'h2F);
        chk("loss_olock",  32'(locked),    32'h1);
        chk("loss_ovalid", 32'(valid_out), 32'h0);
        chk("loss_ogap",   32'(gap),       32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serialtopar_sync.md
# serialtopar_sync

Parametrised serial-to-parallel converter with comma-based word alignment for the PHY receive path. It sits directly after the serial line input in the bit-clock domain. It hunts for the comma symbol at any bit offset, locks framing after a programmable number of aligned commas, and then emits aligned parallel words with a valid strobe. It also tracks IDLE symbols and, optionally, detects loss of alignment.

## Interface
- WORD_W, 8: parallel word width in bits, ≥4.
- COMMA, 8'hBC: comma symbol, WORD_W bits.
- IDLE_SYM, 8'h7C: idle symbol, WORD_W bits.
- LOCK_CNT, 4: aligned commas required to lock, ≥1.
- LOSS_CNT, 3: consecutive misaligned commas that drop lock, ≥1.

Ports:
- clk_32f  input  1  serial bit clock; all logic on posedge. One clock, no other clock domain.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data, one bit per clock, MSB of each word first.
- data_out  output  WORD_W  last aligned word.
- valid_out  output  1  one-cycle pulse, data_out holds a new word while locked.
- idle_out  output  1  idle status.
- locked  output  1  high in state LOCKED.
- comma_det  output  1  one-cycle pulse on any comma match at any offset.

## Operation
- Shift register sh[WORD_W-1:0] shifts left, with the new bit in the LSB. The candidate word is cand = {sh[WORD_W-2:0], serial_in}. All compares use cand.
- bit_cnt (clog2(WORD_W) bits) marks the position in the word. A word boundary occurs when bit_cnt == WORD_W-1. bit_cnt wraps to 0 at the boundary.
- States: HUNT (reset), ALIGN, LOCKED.
- HUNT
  - cand == COMMA at any cycle -> ALIGN, bit_cnt <= 0, comma_cnt <= 1.
  - bit_cnt is don't-care in HUNT.
- ALIGN
  - At a boundary with cand == COMMA: comma_cnt++. If the count reaches LOCK_CNT -> LOCKED.
  - At a boundary with a non-comma word: stay in ALIGN, comma_cnt is held.
  - cand == COMMA off-boundary: resync with bit_cnt <= 0, comma_cnt <= 1, stay in ALIGN.
- LOCKED
  - At every boundary: data_out <= cand, valid_out = 1.
  - cand == IDLE_SYM at a boundary sets idle_out.
  - cand == COMMA at a boundary clears idle_out and clears miss_cnt.
  - Other words leave idle_out unchanged.
- Loss handling is described under Configuration.
- In ALIGN, data_out updates at boundaries but valid_out stays 0.
- The word that completes lock is output with valid_out = 1.
- comma_det pulses in every state.
- Counters saturate and never wrap. comma_cnt saturates at LOCK_CNT, miss_cnt at LOSS_CNT.

## Timing
- Reset values: data_out = 0, valid_out = 0, idle_out = 0, locked = 0, comma_det = 0. sh, bit_cnt, comma_cnt and miss_cnt are all 0. State is HUNT.
- Reset is honoured mid-word or mid-lock at any time. All outputs clear immediately, without waiting for a clock.
- Latency: the last bit of a word is sampled at edge k. data_out, valid_out, idle_out and locked reflect that word after edge k, with no extra pipeline stage.
- comma_det is registered and asserted after the edge at which the match occurred.
- valid_out spacing while locked is exactly WORD_W cycles.
- Resync within ALIGN restarts framing. The next boundary is WORD_W cycles after the resyncing comma.
- The IDLE check and the comma check in the same cycle are mutually exclusive because COMMA != IDLE_SYM.
- If parameters set COMMA == IDLE_SYM, comma handling takes precedence.

## Configuration
- Macro: SERIALTOPAR_LOSS_DETECT_EN.
- With the macro defined, loss of alignment is detected:
  - In LOCKED, each off-boundary comma increments miss_cnt.
  - When miss_cnt reaches LOSS_CNT, the block moves to ALIGN on that edge. It sets bit_cnt <= 0, comma_cnt <= 1, miss_cnt <= 0, locked = 0 and idle_out = 0.
  - In effect, it realigns on the offending comma.
- Without the macro, loss detection is absent:
  - LOCKED is terminal until reset.
  - Off-boundary commas only pulse comma_det.
  - miss_cnt logic is absent.

## Test plan
- Reset value check. Hold reset high, assert reset mid-LOCKED, then release. Required response: all outputs are 0 and the block is in HUNT; after release, 4 aligned BC words give locked = 1 exactly at the 4th word's last bit.
- Offset hunt. Send 3 random bits, then 5×BC, then 0x55 (defaults). Required response: comma_det pulses once per BC; locked rises on the 4th BC; valid_out pulses on BC #4, BC #5 and 0x55 at 8-cycle spacing, with data_out = BC, BC, 55.
- Misaligned comma during ALIGN. Send BC, BC, then a BC shifted by 3 bits, then 4 aligned BC. Required response: framing resyncs to the shifted comma; locked rises on the 3rd BC after the resync; no valid_out before lock.
- IDLE tracking. While locked, send 7C, 00, BC. Required response: idle_out goes 1 after 7C, stays 1 after 00, and drops to 0 after BC.
- Loss detection with SERIALTOPAR_LOSS_DETECT_EN. While locked, inject 3 BC at offset +2 with no aligned BC in between. Required response: locked drops on the 3rd, and data is realigned to offset +2.
- Loss detection without the macro. Run the same stimulus. Required response: locked stays 1, valid_out keeps the old framing, and comma_det pulses 3 times.
